// File: rtl/rt_arb_pkg.sv
// Shared types and width helpers for the response arbiter.
// Defaults match the reference configuration.
package rt_arb_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_EXHAUSTED = 2'd1,
    ST_ERROR     = 2'd2
  } state_t;

  localparam int N_REQ_DEF    = 2;
  localparam int BUDGET_DEF   = 3;
  localparam int DEADLINE_DEF = 2;
  localparam int REFILL_DEF   = 8;

  function automatic int budget_w(input int b);
    return $clog2(b + 1);
  endfunction

  function automatic int wait_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/rt_response_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches ptr+1, ptr+2, ... mod N and returns the first requester.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  // first asserted request after the pointer wins
  always_comb begin
    int j;
    j        = 0;
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        idx_o       = IW'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rt_response_arbiter.sv
// Budgeted round-robin responder arbiter with deadline watchdog.
// Errors are sticky until reset.
module rt_response_arbiter
  import rt_arb_pkg::*;
#(
  parameter int N_REQ         = N_REQ_DEF,
  parameter int BUDGET        = BUDGET_DEF,
  parameter int DEADLINE      = DEADLINE_DEF,
  parameter int REFILL_PERIOD = REFILL_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic                          ctrl_en,
  output logic [N_REQ-1:0]              grant,
  output logic                          rt_get,
  output logic [budget_w(BUDGET)-1:0]   budget_left,
  output logic                          busy_exhausted,
  output logic                          error,
  output logic [$clog2(N_REQ)-1:0]      error_id
);

  localparam int BW = budget_w(BUDGET);
  localparam int WW = wait_w(DEADLINE);
  localparam int IW = $clog2(N_REQ);
  localparam int RW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

  state_t          state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [BW-1:0]   budget_q, budget_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [RW-1:0]   refill_q, refill_d;
  logic            err_q, err_d;
  logic [IW-1:0]   eid_q, eid_d;
  logic [WW-1:0]   wait_q [N_REQ];
  logic [WW-1:0]   wait_d [N_REQ];

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;

  logic             refill_now;
  logic [BW-1:0]    avail;
  logic             elig;
  logic [N_REQ-1:0] win;
  logic             viol;
  logic [IW-1:0]    vid;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  assign refill_now = (REFILL_PERIOD != 0) &&
                      (refill_q == RW'(REFILL_PERIOD - 1));
  assign avail = refill_now ? BW'(BUDGET) : budget_q;
  assign elig  = ctrl_en && (avail != '0) &&
                 (state_q != ST_ERROR) && pick_valid;
  assign win   = elig ? pick_oh : '0;

  // saturating wait counters and lowest-index deadline detect
  always_comb begin
    viol = 1'b0;
    vid  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!req[i] || win[i])
        wait_d[i] = '0;
      else if (wait_q[i] != WW'(DEADLINE))
        wait_d[i] = wait_q[i] + 1'b1;
      else
        wait_d[i] = wait_q[i];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (state_q != ST_ERROR && wait_d[i] == WW'(DEADLINE)) begin
        viol = 1'b1;
        vid  = IW'(i);
      end
    end
  end

  // next-state: error freezes everything, violation beats grant/refill
  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    budget_d = budget_q;
    ptr_d    = ptr_q;
    refill_d = refill_q;
    err_d    = err_q;
    eid_d    = eid_q;
    if (state_q != ST_ERROR) begin
      refill_d = refill_now ? '0 : refill_q + 1'b1;
      if (viol) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
        eid_d   = vid;
      end else begin
        grant_d = win;
        if (elig) begin
          ptr_d    = pick_idx;
          budget_d = avail - 1'b1;
        end else begin
          budget_d = avail;
        end
        state_d = (budget_d == '0) ? ST_EXHAUSTED : ST_ACTIVE;
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ACTIVE;
      grant_q  <= '0;
      budget_q <= BW'(BUDGET);
      ptr_q    <= IW'(N_REQ - 1);
      refill_q <= '0;
      err_q    <= 1'b0;
      eid_q    <= '0;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      budget_q <= budget_d;
      ptr_q    <= ptr_d;
      refill_q <= refill_d;
      err_q    <= err_d;
      eid_q    <= eid_d;
      if (state_q != ST_ERROR)
        for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign grant          = grant_q;
  assign rt_get         = |req;
  assign budget_left    = budget_q;
  assign busy_exhausted = (state_q == ST_EXHAUSTED);
  assign error          = err_q;
  assign error_id       = eid_q;

endmodule

// File: tb/tb_rt_response_arbiter.sv
// Scoreboard bench for rt_response_arbiter across three configurations.
// A: defaults, B: BUDGET=8, C: REFILL_PERIOD=4 DEADLINE=4.
module tb_rt_response_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_a = '0, req_b = '0, req_c = '0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

  logic [1:0] g_a, g_b, g_c;
  logic rg_a, rg_b, rg_c;
  logic [1:0] bl_a, bl_c;
  logic [3:0] bl_b;
  logic ex_a, ex_b, ex_c;
  logic er_a, er_b, er_c;
  logic id_a, id_b, id_c;

  always #5 clk = ~clk;

  rt_response_arbiter u_a (
    .clk(clk), .reset(reset), .req(req_a), .ctrl_en(en_a),
    .grant(g_a), .rt_get(rg_a), .budget_left(bl_a),
    .busy_exhausted(ex_a), .error(er_a), .error_id(id_a)
  );

  rt_response_arbiter #(.BUDGET(8)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .ctrl_en(en_b),
    .grant(g_b), .rt_get(rg_b), .budget_left(bl_b),
    .busy_exhausted(ex_b), .error(er_b), .error_id(id_b)
  );

  rt_response_arbiter #(.BUDGET(3), .REFILL_PERIOD(4), .DEADLINE(4)) u_c (
    .clk(clk), .reset(reset), .req(req_c), .ctrl_en(en_c),
    .grant(g_c), .rt_get(rg_c), .budget_left(bl_c),
    .busy_exhausted(ex_c), .error(er_c), .error_id(id_c)
  );

  // observation layout: grant[9:8] budget[7:4] exh[3] err[2] eid[1] rt_get[0]
  typedef struct {
    string      tag;
    int         d;
    logic [9:0] v;
    logic [9:0] m;
  } exp_t;

  exp_t sbq[$];
  int ncmp = 0;
  int nerr = 0;

  function automatic logic [9:0] obs(input int d);
    case (d)
      0:       return {g_a, 4'(bl_a), ex_a, er_a, id_a, rg_a};
      1:       return {g_b, bl_b, ex_b, er_b, id_b, rg_b};
      default: return {g_c, 4'(bl_c), ex_c, er_c, id_c, rg_c};
    endcase
  endfunction

  // -1 in any field means don't care
  task automatic push(input string tag, input int d, input int g,
                      input int bl, input int ex, input int er,
                      input int eid, input int rg);
    exp_t e;
    e.tag = tag;
    e.d   = d;
    e.v   = '0;
    e.m   = '0;
    if (g >= 0)   begin e.v[9:8] = g[1:0];  e.m[9:8] = 2'b11;   end
    if (bl >= 0)  begin e.v[7:4] = bl[3:0]; e.m[7:4] = 4'b1111; end
    if (ex >= 0)  begin e.v[3]   = ex[0];   e.m[3]   = 1'b1;    end
    if (er >= 0)  begin e.v[2]   = er[0];   e.m[2]   = 1'b1;    end
    if (eid >= 0) begin e.v[1]   = eid[0];  e.m[1]   = 1'b1;    end
    if (rg >= 0)  begin e.v[0]   = rg[0];   e.m[0]   = 1'b1;    end
    sbq.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    logic [9:0] o;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.d);
      ncmp++;
      assert ((o & e.m) === (e.v & e.m)) else begin
        nerr++;
        $error("FAIL %s observed=%b expected=%b mask=%b",
               e.tag, o, e.v, e.m);
      end
    end
  endtask

  task automatic push_reset();
    push("rst_a", 0, 0, 3, 0, 0, 0, -1);
    push("rst_b", 1, 0, 8, 0, 0, 0, -1);
    push("rst_c", 2, 0, 3, 0, 0, 0, -1);
  endtask

  initial begin
    reset = 1'b1;
    push_reset();
    cyc();

    // T1 on A, T2 on B, T4 on C in parallel
    reset = 1'b0;
    req_a = 2'b01; en_a = 1'b1;
    req_b = 2'b11; en_b = 1'b1;
    req_c = 2'b01; en_c = 1'b1;
    push("t1_e1", 0, 1, 2, 0, 0, -1, 1);
    push("t2_e1", 1, 1, 7, 0, 0, -1, 1);
    push("t4_e1", 2, 1, 2, 0, 0, -1, 1);
    cyc();
    push("t1_e2", 0, 1, 1, 0, 0, -1, 1);
    push("t2_e2", 1, 2, 6, 0, 0, -1, 1);
    push("t4_e2", 2, 1, 1, 0, 0, -1, 1);
    cyc();
    push("t1_e3", 0, 1, 0, 1, 0, -1, 1);
    push("t2_e3", 1, 1, 5, 0, 0, -1, 1);
    push("t4_e3", 2, 1, 0, 1, 0, -1, 1);
    cyc();
    push("t1_e4", 0, 0, 0, 1, 0, -1, 1);
    push("t2_e4", 1, 2, 4, 0, 0, -1, 1);
    push("t4_e4_refill", 2, 1, 2, 0, 0, -1, 1);
    cyc();
    push("t1_e5_err", 0, 0, 0, -1, 1, 0, 1);
    push("t2_e5", 1, 1, 3, 0, 0, -1, 1);
    push("t4_e5", 2, 1, 1, 0, 0, -1, 1);
    cyc();
    push("t1_e6_hold", 0, 0, 0, -1, 1, 0, -1);
    push("t2_e6", 1, 2, 2, 0, 0, -1, 1);
    push("t4_e6", 2, 1, 0, 1, 0, -1, 1);
    cyc();
    push("t1_e7_hold", 0, 0, 0, -1, 1, 0, -1);
    cyc();

    // T5: reset out of ST_ERROR, then req=11
    reset = 1'b1;
    push_reset();
    cyc();
    reset = 1'b0;
    req_a = 2'b11; en_a = 1'b1;
    req_b = 2'b00; en_b = 1'b0;
    req_c = 2'b00; en_c = 1'b0;
    push("t5_first", 0, 1, 2, 0, 0, -1, 1);
    push("idle_b", 1, 0, 8, 0, 0, -1, 0);
    cyc();

    // T6: both starve, lowest index reported
    reset = 1'b1;
    push_reset();
    cyc();
    reset = 1'b0;
    req_a = 2'b11; en_a = 1'b0;
    push("t6_e1", 0, 0, 3, 0, 0, -1, 1);
    cyc();
    push("t6_e2_err", 0, 0, 3, -1, 1, 0, 1);
    cyc();

    // T3: requester 1 starved by ctrl_en=0
    reset = 1'b1;
    push_reset();
    cyc();
    reset = 1'b0;
    req_a = 2'b10; en_a = 1'b0;
    push("t3_e1", 0, 0, 3, 0, 0, -1, 1);
    cyc();
    push("t3_e2_err", 0, 0, 3, -1, 1, 1, 1);
    cyc();
    en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push($sformatf("t3_sticky%0d", i), 0, 0, 3, -1, 1, 1, 1);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/rt_response_arbiter.md
Name: rt_response_arbiter

Overview:
- Shares one bounded-capacity responder among N_REQ requesters. It is the scheduler for the "respond while budget remains, else flag error" bench pattern.
- Issues round-robin one-hot grants, gated by a controllable enable from the synthesis environment.
- Tracks a grant budget with periodic refill.
- Raises a sticky error when any requester waits DEADLINE consecutive cycles unserved. Sits between the request sources and the responder; the error output feeds the model-checking/synthesis harness.

Parameters:
- N_REQ, 2, number of requesters (>=2)
- BUDGET, 3, grants available per refill window (>=1)
- DEADLINE, 2, consecutive unserved request cycles that trigger error (>=1)
- REFILL_PERIOD, 8, cycles between budget refills; 0 = never refill (one-shot budget)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request level, sampled at clk
- ctrl_en  in  1  controllable permission; 0 forbids any grant this cycle
- grant  out  N_REQ  registered one-hot (or zero) grant
- rt_get  out  1  combinational OR of req (rt event, preconditioned on clk sampling)
- budget_left  out  $clog2(BUDGET+1)  remaining grants, registered
- busy_exhausted  out  1  high in ST_EXHAUSTED
- error  out  1  sticky deadline violation
- error_id  out  $clog2(N_REQ)  index of first violating requester

Behaviour:
- Reset values (next edge with reset=1): grant=0, budget_left=BUDGET, error=0, error_id=0, state=ST_ACTIVE, rr pointer=N_REQ-1 (requester 0 wins first), all wait counters=0, refill_cnt=0. Reset wins over every other event, including mid-grant and in ST_ERROR.
- refill_now = (REFILL_PERIOD!=0) && refill_cnt==REFILL_PERIOD-1.
- refill_cnt increments every non-reset cycle and wraps to 0 on refill_now. It runs in all states except ST_ERROR, where it freezes.
- avail = refill_now ? BUDGET : budget_left.
- eligible = ctrl_en && avail!=0 && state!=ST_ERROR && |req.
- Round robin: winner = first requester with req high, searching ptr+1, ptr+2, ... mod N_REQ.
- Latency 1: if eligible at cycle t, then at edge t+1: grant=onehot(winner), ptr=winner, budget_left=avail-1. Otherwise grant=0 and budget_left=avail.
- grant is a one-cycle pulse per decision. Back-to-back grants are allowed every cycle.
- Wait counter i (width $clog2(DEADLINE+1), saturating):
  - cleared if req[i]=0 or requester i wins this cycle;
  - otherwise incremented.
- Deadline violation: any counter reaching DEADLINE at an edge sets error=1 at that edge, error_id=lowest such index, state=ST_ERROR.
- ST_ERROR: grant held 0, budget_left frozen, error/error_id held until reset.
- States:
  - ST_ACTIVE -> ST_EXHAUSTED when the new budget_left=0.
  - ST_EXHAUSTED -> ST_ACTIVE on refill.
  - any state -> ST_ERROR on violation. Violation takes priority over a simultaneous refill or grant; grant is suppressed on that edge.
- Refill and grant on the same edge: budget_left=BUDGET-1.
- budget_left never underflows. With REFILL_PERIOD=0 the block stays in ST_EXHAUSTED forever once the budget is spent.

Decomposition:
- Package rt_arb_pkg:
  - state enum {ST_ACTIVE, ST_EXHAUSTED, ST_ERROR};
  - default parameter constants;
  - width helper functions for budget and wait counters.
- Sub-module rr_pick: purely combinational round-robin picker. Inputs req and ptr; outputs valid, winner index, one-hot. Verified standalone.
- The top holds the FSM, the budget/refill counters and the wait counters.

Test Plan:
1. Defaults, req=01, ctrl_en=1 held:
   - grant=01 at edges 1,2,3; budget_left=2,1,0; busy_exhausted=1 after edge 3.
   - wait0=1 at edge 4; error=1, error_id=0 at edge 5; grant=0 afterwards.
2. BUDGET=8, req=11, ctrl_en=1:
   - grant alternates 01,10,01,10 on edges 1-4; no error; rt_get=1 throughout.
3. Defaults, req=10, ctrl_en=0:
   - no grant; error=1, error_id=1 at edge 2.
   - Then ctrl_en=1 for 5 cycles: grant stays 0, error stays 1.
4. BUDGET=3, REFILL_PERIOD=4, DEADLINE=4, req=01, ctrl_en=1:
   - grants at edges 1-3, budget 0 after edge 3.
   - Edge 4 refill+grant: grant=01, budget_left=2, busy_exhausted=0; no error.
5. Defaults, scenario 1 run to error:
   - reset=1 for one cycle: all outputs at reset values next edge.
   - reset=0, req=11: first grant=01.
6. Defaults, req=11, ctrl_en=0:
   - both wait counters reach 2 at edge 2; error=1, error_id=0 (lowest index wins).
